// File: rtl/pipe_hazard_ctrl.sv
// Purpose : central stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EXE, EXE/MEM).
// Latency : outputs are combinational from state, remain_cnt and current inputs; no added cycles.
// Backpr. : dmem_busy freezes every stage and holds all internal state and counters.
//
// Ports:
//   clk, rst                     pipeline clock (rising edge), async active-low reset
//   id_raddr1/2, id_use1/2       source operands of the instruction in ID
//   ex_mem_read, ex_wen, ex_waddr  destination/load info of the instruction in EXE
//   ex_branch_taken, ex_jal      redirect requests resolved in EXE
//   dmem_busy                    data memory not ready, freezes the pipeline
//   pc_en, pc_redirect           PC update enable and EXE-target select
//   ifid_en, ifid_flush          IF/ID load enable and NOP insert
//   idex_en, idex_bubble         ID/EXE load enable and control-zeroing
//   exmem_en                     EXE/MEM load enable
//   state_o                      FSM state for debug
//   stall_cnt, flush_cnt         saturating load-use bubble / redirect event counters
module pipe_hazard_ctrl #(
   parameter int ASIZE          = 4,
   parameter int LOAD_BUBBLES   = 1,
   parameter int REDIRECT_EXTRA = 1,
   parameter int CW             = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ASIZE-1:0] id_raddr1,
   input  logic [ASIZE-1:0] id_raddr2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic             ex_mem_read,
   input  logic             ex_wen,
   input  logic [ASIZE-1:0] ex_waddr,
   input  logic             ex_branch_taken,
   input  logic             ex_jal,
   input  logic             dmem_busy,
   output logic             pc_en,
   output logic             pc_redirect,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_bubble,
   output logic             exmem_en,
   output logic [1:0]       state_o,
   output logic [CW-1:0]    stall_cnt,
   output logic [CW-1:0]    flush_cnt
);

   localparam logic [1:0]    S_RUN   = 2'd0;
   localparam logic [1:0]    S_LU    = 2'd1;
   localparam logic [1:0]    S_REDIR = 2'd2;

   localparam logic [2:0]    LB_REM  = 3'(LOAD_BUBBLES - 1);
   localparam logic [2:0]    RE_REM  = 3'(REDIRECT_EXTRA);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [2:0] remain_cnt;
   logic [2:0] remain_nxt;
   logic       stall_inc;
   logic       flush_inc;
   logic       redirect;
   logic       load_use;
   logic       src1_hit;
   logic       src2_hit;

   assign redirect = ex_branch_taken | ex_jal;
   assign src1_hit = id_use1 & (id_raddr1 == ex_waddr);
   assign src2_hit = id_use2 & (id_raddr2 == ex_waddr);
   assign load_use = ex_mem_read & ex_wen & (ex_waddr != '0) & (src1_hit | src2_hit);
   assign state_o  = state;

   always_comb begin
      pc_en       = 1'b0;
      pc_redirect = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_bubble = 1'b0;
      exmem_en    = 1'b0;
      state_nxt   = state;
      remain_nxt  = remain_cnt;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      // Reset gating here keeps every enable low while rst is held, even though
      // the flops are already cleared; frozen cycles leave everything at default.
      if (rst && !dmem_busy) begin
         if (redirect) begin
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
            flush_inc   = 1'b1;
            // Any pending load-use sequence is dropped: its instruction is on the wrong path.
            if (REDIRECT_EXTRA > 0) begin
               state_nxt  = S_REDIR;
               remain_nxt = RE_REM;
            end else begin
               state_nxt  = S_RUN;
               remain_nxt = 3'd0;
            end
         end else begin
            case (state)
               S_LU: begin
                  idex_en     = 1'b1;
                  idex_bubble = 1'b1;
                  exmem_en    = 1'b1;
                  stall_inc   = 1'b1;
                  remain_nxt  = remain_cnt - 3'd1;
                  // <= guards against an unexpected zero count wrapping to 7.
                  if (remain_cnt <= 3'd1) begin
                     state_nxt  = S_RUN;
                     remain_nxt = 3'd0;
                  end
               end
               S_REDIR: begin
                  // ID holds a squashed NOP here, so load_use is deliberately ignored.
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_en     = 1'b1;
                  idex_bubble = 1'b1;
                  exmem_en    = 1'b1;
                  remain_nxt  = remain_cnt - 3'd1;
                  if (remain_cnt <= 3'd1) begin
                     state_nxt  = S_RUN;
                     remain_nxt = 3'd0;
                  end
               end
               S_RUN: begin
                  if (load_use) begin
                     idex_en     = 1'b1;
                     idex_bubble = 1'b1;
                     exmem_en    = 1'b1;
                     stall_inc   = 1'b1;
                     if (LOAD_BUBBLES > 1) begin
                        state_nxt  = S_LU;
                        remain_nxt = LB_REM;
                     end
                  end else begin
                     pc_en    = 1'b1;
                     ifid_en  = 1'b1;
                     idex_en  = 1'b1;
                     exmem_en = 1'b1;
                  end
               end
               default: begin
                  // Unreachable encoding: behave as a plain run cycle and recover.
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  state_nxt  = S_RUN;
                  remain_nxt = 3'd0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_RUN;
         remain_cnt <= 3'd0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         remain_cnt <= remain_nxt;
         if (stall_inc && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (flush_inc && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : directed check of pipe_hazard_ctrl in two configurations via an expected-response queue.
// Latency : one vector per clock; outputs sampled on the falling edge of the same cycle.
// Backpr. : dmem_busy freeze vectors are part of the stimulus table.
module tb_pipe_hazard_ctrl;

   logic clk;
   logic rst;

   logic [3:0] raddr1   [2];
   logic [3:0] raddr2   [2];
   logic       use1     [2];
   logic       use2     [2];
   logic       mem_read [2];
   logic       wen      [2];
   logic [3:0] waddr    [2];
   logic       br_taken [2];
   logic       jal      [2];
   logic       busy     [2];

   logic       pc_en       [2];
   logic       pc_redirect [2];
   logic       ifid_en     [2];
   logic       ifid_flush  [2];
   logic       idex_en     [2];
   logic       idex_bubble [2];
   logic       exmem_en    [2];
   logic [1:0] state_o     [2];
   logic [15:0] stall0;
   logic [15:0] flush0;
   logic [3:0]  stall1;
   logic [3:0]  flush1;

   // ctl vector order: {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en}
   localparam logic [6:0] C_RUN = 7'b1010101;
   localparam logic [6:0] C_LU  = 7'b0000111;
   localparam logic [6:0] C_RED = 7'b1111111;
   localparam logic [6:0] C_RDX = 7'b1011111;
   localparam logic [6:0] C_OFF = 7'b0000000;

   typedef struct {
      int          d;
      logic [6:0]  ctl;
      logic [1:0]  st;
      logic [15:0] sc;
      logic [15:0] fc;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_vec;
   int   n_err;

   pipe_hazard_ctrl #(.ASIZE(4), .LOAD_BUBBLES(1), .REDIRECT_EXTRA(1), .CW(16)) u_dut0 (
      .clk(clk), .rst(rst),
      .id_raddr1(raddr1[0]), .id_raddr2(raddr2[0]), .id_use1(use1[0]), .id_use2(use2[0]),
      .ex_mem_read(mem_read[0]), .ex_wen(wen[0]), .ex_waddr(waddr[0]),
      .ex_branch_taken(br_taken[0]), .ex_jal(jal[0]), .dmem_busy(busy[0]),
      .pc_en(pc_en[0]), .pc_redirect(pc_redirect[0]), .ifid_en(ifid_en[0]),
      .ifid_flush(ifid_flush[0]), .idex_en(idex_en[0]), .idex_bubble(idex_bubble[0]),
      .exmem_en(exmem_en[0]), .state_o(state_o[0]), .stall_cnt(stall0), .flush_cnt(flush0)
   );

   pipe_hazard_ctrl #(.ASIZE(4), .LOAD_BUBBLES(3), .REDIRECT_EXTRA(1), .CW(4)) u_dut1 (
      .clk(clk), .rst(rst),
      .id_raddr1(raddr1[1]), .id_raddr2(raddr2[1]), .id_use1(use1[1]), .id_use2(use2[1]),
      .ex_mem_read(mem_read[1]), .ex_wen(wen[1]), .ex_waddr(waddr[1]),
      .ex_branch_taken(br_taken[1]), .ex_jal(jal[1]), .dmem_busy(busy[1]),
      .pc_en(pc_en[1]), .pc_redirect(pc_redirect[1]), .ifid_en(ifid_en[1]),
      .ifid_flush(ifid_flush[1]), .idex_en(idex_en[1]), .idex_bubble(idex_bubble[1]),
      .exmem_en(exmem_en[1]), .state_o(state_o[1]), .stall_cnt(stall1), .flush_cnt(flush1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // hz: 0 idle, 1 load-use on src1, 2 load to r0, 3 src1 matches but unused, 4 load-use on src2
   task automatic apply(input int d, input int hz, input logic bt, input logic jl, input logic bz,
                        input logic [6:0] ctl, input logic [1:0] st,
                        input logic [15:0] sc, input logic [15:0] fc, input string nm);
      exp_t e;
      mem_read[d] = (hz != 0);
      wen[d]      = (hz != 0);
      waddr[d]    = (hz == 2) ? 4'd0 : 4'd3;
      raddr1[d]   = (hz == 2) ? 4'd0 : ((hz == 4) ? 4'd5 : 4'd3);
      raddr2[d]   = (hz == 4) ? 4'd3 : 4'd6;
      use1[d]     = (hz == 1) || (hz == 2) || (hz == 4);
      use2[d]     = (hz == 4);
      br_taken[d] = bt;
      jal[d]      = jl;
      busy[d]     = bz;
      e.d   = d;
      e.ctl = ctl;
      e.st  = st;
      e.sc  = sc;
      e.fc  = fc;
      e.nm  = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every falling edge with a pending expectation is one compared vector.
   exp_t        m_e;
   logic [6:0]  a_ctl;
   logic [1:0]  a_st;
   logic [15:0] a_sc;
   logic [15:0] a_fc;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         m_e = sb.pop_front();
         if (m_e.d == 0) begin
            a_ctl = {pc_en[0], pc_redirect[0], ifid_en[0], ifid_flush[0], idex_en[0], idex_bubble[0], exmem_en[0]};
            a_st  = state_o[0];
            a_sc  = stall0;
            a_fc  = flush0;
         end else begin
            a_ctl = {pc_en[1], pc_redirect[1], ifid_en[1], ifid_flush[1], idex_en[1], idex_bubble[1], exmem_en[1]};
            a_st  = state_o[1];
            a_sc  = {12'd0, stall1};
            a_fc  = {12'd0, flush1};
         end
         n_vec++;
         if ((a_ctl !== m_e.ctl) || (a_st !== m_e.st) || (a_sc !== m_e.sc) || (a_fc !== m_e.fc)) begin
            n_err++;
            $display("FAIL %s (dut%0d): got ctl=%b st=%0d stall=%0d flush=%0d, expected ctl=%b st=%0d stall=%0d flush=%0d",
                     m_e.nm, m_e.d, a_ctl, a_st, a_sc, a_fc, m_e.ctl, m_e.st, m_e.sc, m_e.fc);
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      for (int k = 0; k < 2; k++) begin
         raddr1[k] = '0; raddr2[k] = '0; use1[k] = 1'b0; use2[k] = 1'b0;
         mem_read[k] = 1'b0; wen[k] = 1'b0; waddr[k] = '0;
         br_taken[k] = 1'b0; jal[k] = 1'b0; busy[k] = 1'b0;
      end
      @(posedge clk);
      #1;

      // Reset state, both configurations
      apply(0, 0, 0, 0, 0, C_OFF, 2'd0, 16'd0, 16'd0, "reset0");
      apply(1, 0, 0, 0, 0, C_OFF, 2'd0, 16'd0, 16'd0, "reset1");
      rst = 1'b1;

      // Configuration 0: LOAD_BUBBLES=1, REDIRECT_EXTRA=1, CW=16
      apply(0, 0, 0, 0, 0, C_RUN, 2'd0, 16'd0, 16'd0, "idle");
      apply(0, 1, 0, 0, 0, C_LU,  2'd0, 16'd0, 16'd0, "lu_src1");
      apply(0, 0, 0, 0, 0, C_RUN, 2'd0, 16'd1, 16'd0, "after_lu");
      apply(0, 2, 0, 0, 0, C_RUN, 2'd0, 16'd1, 16'd0, "load_r0");
      apply(0, 3, 0, 0, 0, C_RUN, 2'd0, 16'd1, 16'd0, "src_unused");
      apply(0, 4, 0, 0, 0, C_LU,  2'd0, 16'd1, 16'd0, "lu_src2");
      apply(0, 0, 0, 0, 0, C_RUN, 2'd0, 16'd2, 16'd0, "after_lu2");
      apply(0, 0, 1, 0, 0, C_RED, 2'd0, 16'd2, 16'd0, "branch_c0");
      apply(0, 0, 0, 0, 0, C_RDX, 2'd2, 16'd2, 16'd1, "branch_c1");
      apply(0, 0, 0, 0, 0, C_RUN, 2'd0, 16'd2, 16'd1, "branch_c2");
      apply(0, 1, 0, 1, 0, C_RED, 2'd0, 16'd2, 16'd1, "jal_over_lu");
      apply(0, 1, 0, 0, 0, C_RDX, 2'd2, 16'd2, 16'd2, "lu_in_redir");
      apply(0, 0, 0, 0, 0, C_RUN, 2'd0, 16'd2, 16'd2, "redir_done");
      apply(0, 0, 1, 0, 1, C_OFF, 2'd0, 16'd2, 16'd2, "freeze_branch");
      apply(0, 0, 0, 0, 0, C_RUN, 2'd0, 16'd2, 16'd2, "unfreeze");

      // Configuration 1: LOAD_BUBBLES=3, REDIRECT_EXTRA=1, CW=4
      apply(1, 0, 0, 0, 0, C_RUN, 2'd0, 16'd0, 16'd0, "idle1");
      apply(1, 1, 0, 0, 0, C_LU,  2'd0, 16'd0, 16'd0, "lu3_b1");
      apply(1, 0, 0, 0, 0, C_LU,  2'd1, 16'd1, 16'd0, "lu3_b2");
      apply(1, 0, 0, 0, 1, C_OFF, 2'd1, 16'd2, 16'd0, "lu3_busy1");
      apply(1, 0, 0, 0, 1, C_OFF, 2'd1, 16'd2, 16'd0, "lu3_busy2");
      apply(1, 0, 0, 0, 0, C_LU,  2'd1, 16'd2, 16'd0, "lu3_b3");
      apply(1, 0, 0, 0, 0, C_RUN, 2'd0, 16'd3, 16'd0, "lu3_done");
      for (int i = 0; i < 15; i++) begin
         apply(1, 1, 0, 0, 0, C_LU, (i % 3 == 0) ? 2'd0 : 2'd1,
               (3 + i > 15) ? 16'd15 : 16'(3 + i), 16'd0, "sat_run");
      end
      apply(1, 0, 0, 0, 0, C_RUN, 2'd0, 16'd15, 16'd0, "sat_hold");

      // Asynchronous reset landing in the middle of a REDIR sequence
      apply(0, 0, 0, 1, 0, C_RED, 2'd0, 16'd2, 16'd2, "jal_pre_rst");
      rst = 1'b0;
      apply(0, 0, 0, 0, 0, C_OFF, 2'd0, 16'd0, 16'd0, "async_rst");
      rst = 1'b1;
      apply(0, 0, 0, 0, 0, C_RUN, 2'd0, 16'd0, 16'd0, "post_rst0");
      apply(1, 0, 0, 0, 0, C_RUN, 2'd0, 16'd0, 16'd0, "post_rst1");

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Decides each cycle whether PC, IF/ID, ID/EXE and EXE/MEM advance, hold, take a bubble or are squashed.
- Bubbles are inserted at ID/EXE by zeroing its control inputs (wen, mem_read, mem_write, mem_to_reg, branch, jal) under idex_bubble.
- Holds multi-cycle load-use and redirect sequences in a small FSM and keeps saturating event counters for performance debug.

Parameters:
- ASIZE, 4, register address width (matches register file).
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (1..7).
- REDIRECT_EXTRA, 1, extra wrong-path fetch cycles squashed after a redirect (0..7).
- CW, 16, width of performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_raddr1  in  ASIZE  source register 1 of instruction in ID.
- id_raddr2  in  ASIZE  source register 2 of instruction in ID.
- id_use1  in  1  ID instruction reads raddr1.
- id_use2  in  1  ID instruction reads raddr2.
- ex_mem_read  in  1  instruction in EXE is a load (ID/EXE mem_read_out).
- ex_wen  in  1  ID/EXE wen_out1.
- ex_waddr  in  ASIZE  ID/EXE waddr_out.
- ex_branch_taken  in  1  branch in EXE resolved taken.
- ex_jal  in  1  ID/EXE jal_out.
- dmem_busy  in  1  data memory not ready; freezes the whole pipeline.
- pc_en  out  1  PC register update enable.
- pc_redirect  out  1  PC mux selects EXE target.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_en  out  1  ID/EXE load enable.
- idex_bubble  out  1  ID/EXE control inputs forced to 0.
- exmem_en  out  1  EXE/MEM load enable.
- state_o  out  2  FSM state (debug).
- stall_cnt  out  CW  load-use bubble cycles, saturating.
- flush_cnt  out  CW  redirect events, saturating.

Behaviour:
- Conditions:
  - redirect = ex_branch_taken | ex_jal.
  - load_use = ex_mem_read & ex_wen & (ex_waddr != 0) & ((id_use1 & id_raddr1 == ex_waddr) | (id_use2 & id_raddr2 == ex_waddr)).
- Reset:
  - While rst = 0, state = RUN (2'd0) and remain_cnt = 0.
  - stall_cnt = flush_cnt = 0.
  - All enables are forced to 0; pc_redirect, ifid_flush and idex_bubble are 0.
  - Reset is asynchronous and may assert mid-sequence; any stall or squash in progress is abandoned.
- Outputs are combinational from state, remain_cnt and the current inputs. No added latency.
- Priority in every state: freeze > redirect > state action > load_use > run.
- Freeze (dmem_busy = 1):
  - All enables are 0; pc_redirect, ifid_flush and idex_bubble are 0.
  - State, remain_cnt and counters hold.
- Redirect (any state, not frozen):
  - pc_en = 1, pc_redirect = 1, ifid_en = 1, ifid_flush = 1, idex_en = 1, idex_bubble = 1, exmem_en = 1.
  - flush_cnt increments.
  - If REDIRECT_EXTRA > 0: next state REDIR (2'd2) with remain_cnt = REDIRECT_EXTRA. Otherwise next state RUN.
  - A pending LU sequence is cancelled.
- RUN, load_use:
  - pc_en = 0, ifid_en = 0, idex_en = 1, idex_bubble = 1, exmem_en = 1.
  - stall_cnt increments.
  - If LOAD_BUBBLES > 1: next state LU (2'd1) with remain_cnt = LOAD_BUBBLES-1.
- RUN, otherwise: all enables are 1; flush and bubble are 0.
- LU:
  - Same outputs as a load-use cycle; stall_cnt increments; remain_cnt decrements.
  - When remain_cnt == 1, next state is RUN.
- REDIR:
  - pc_en = 1, pc_redirect = 0, ifid_en = 1, ifid_flush = 1, idex_en = 1, idex_bubble = 1, exmem_en = 1.
  - remain_cnt decrements; when remain_cnt == 1, next state is RUN.
  - A load_use seen in REDIR is ignored, because the ID stage holds a squashed NOP.
- Counters saturate at {CW{1'b1}} and never wrap.
- state 2'd3 is unreachable; if entered, the FSM returns to RUN on the next clock.

Test Plan:
- Load r3 in EXE (ex_mem_read = 1, ex_wen = 1, ex_waddr = 3), ID instruction with id_use1 = 1, id_raddr1 = 3, LOAD_BUBBLES = 1 → exactly one cycle with pc_en = 0, ifid_en = 0, idex_bubble = 1; stall_cnt = 1; the next cycle has all enables 1.
- Same hazard with ex_waddr = 0, or with id_use1 = 0 → no stall; stall_cnt stays 0.
- ex_branch_taken = 1 for one cycle, REDIRECT_EXTRA = 1 → cycle 0: pc_redirect = 1, ifid_flush = 1, idex_bubble = 1; cycle 1: ifid_flush = 1, pc_redirect = 0; cycle 2: RUN; flush_cnt = 1.
- load_use and ex_jal high in the same cycle → redirect wins: pc_en = 1, stall_cnt unchanged, flush_cnt += 1.
- LOAD_BUBBLES = 3, with dmem_busy = 1 for 2 cycles during LU → all enables 0 while busy, remain_cnt held; 3 bubble cycles in total; stall_cnt = 3.
- rst driven low asynchronously mid-REDIR → state_o = 0 and all outputs 0 immediately. After release with no hazard → all enables 1.
- stall_cnt preloaded to near saturation by a long hazard run with CW = 4 → stops at 15.
